free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list.sv | 176 +++++++++++++++++
 tb/tb_free_list.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// free_list -- circular free list of physical register indices for rename.
//
// Holds up to P_REGS preg indices between a head (allocation) pointer and a
// tail (release) pointer. Rename pops up to two pregs per cycle with an
// all-or-nothing grant, and commit pushes up to two pregs per cycle. The head
// pointer can be snapshotted into C_NUM checkpoint slots and restored on a
// mispredict.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   pop_1, pop_2                 allocation requests from rename slots 1/2
//   alloc_data_1, alloc_data_2   pregs offered to rename (combinational)
//   alloc_ready                  every requested pop can be granted
//   push_en_1/2, push_data_1/2   pregs released at commit
//   take_checkpoint, dual_branch snapshot head (one or two slots)
//   current_id                   next checkpoint slot to be written
//   restore_flist, restore_id    reload head from a checkpoint slot
//   free_count                   number of free pregs held
//   low_water                    fewer than 4 free pregs
//
// Build option
//   FREE_LIST_LOW_WATER_EN  when defined, low_water is a registered flag
//                           (next free_count < 4); otherwise tied to 0.

module free_list #(
   parameter int P_ADDR_WIDTH = 7,
   parameter int L_ADDR_WIDTH = 5,
   parameter int C_NUM        = 2,
   localparam int C_W         = $clog2(C_NUM)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pop_1,
   input  logic                    pop_2,
   output logic [P_ADDR_WIDTH-1:0] alloc_data_1,
   output logic [P_ADDR_WIDTH-1:0] alloc_data_2,
   output logic                    alloc_ready,
   input  logic                    push_en_1,
   input  logic                    push_en_2,
   input  logic [P_ADDR_WIDTH-1:0] push_data_1,
   input  logic [P_ADDR_WIDTH-1:0] push_data_2,
   input  logic                    take_checkpoint,
   input  logic                    dual_branch,
   output logic [C_W-1:0]          current_id,
   input  logic                    restore_flist,
   input  logic [C_W-1:0]          restore_id,
   output logic [P_ADDR_WIDTH:0]   free_count,
   output logic                    low_water
);

   localparam int P_REGS   = 2 ** P_ADDR_WIDTH;
   localparam int L_REGS   = 2 ** L_ADDR_WIDTH;
   localparam int INIT_CNT = P_REGS - 8 - L_REGS;

   typedef logic [P_ADDR_WIDTH-1:0] ptr_t;
   typedef logic [P_ADDR_WIDTH:0]   cnt_t;

   ptr_t           mem_q [P_REGS];
   ptr_t           ckpt_q [C_NUM];
   ptr_t           head_q, head_d;
   ptr_t           tail_q, tail_d;
   cnt_t           count_q, count_d;
   logic [C_W-1:0] cid_q, cid_d;

   logic [1:0] pop_cnt;
   logic [1:0] push_cnt;
   logic [1:0] granted;
   ptr_t       head_p1;
   ptr_t       head_p12;
   ptr_t       head_g;
   cnt_t       pre_cnt;
   ptr_t       diff;

   assign pop_cnt  = {1'b0, pop_1} + {1'b0, pop_2};
   assign push_cnt = {1'b0, push_en_1} + {1'b0, push_en_2};

   assign alloc_ready = (count_q >= cnt_t'(pop_cnt));
   assign granted     = (alloc_ready && !restore_flist) ? pop_cnt : 2'd0;

   assign head_p1  = head_q + ptr_t'(pop_1);
   assign head_p12 = head_q + ptr_t'(pop_cnt);
   assign head_g   = head_q + ptr_t'(granted);

   assign alloc_data_1 = mem_q[head_q];
   assign alloc_data_2 = mem_q[head_p1];

   assign free_count = count_q;
   assign current_id = cid_q;

   always_comb begin
      tail_d  = tail_q + ptr_t'(push_cnt);
      pre_cnt = count_q + cnt_t'(push_cnt);
      head_d  = head_g;
      count_d = pre_cnt - cnt_t'(granted);
      diff    = '0;
      if (restore_flist) begin
         head_d = ckpt_q[restore_id];
         diff   = tail_d - head_d;
         // A restore only moves head back over entries already handed out,
         // so coincident pointers mean a full list unless the list was empty
         // (in which case head cannot have moved).
         if (diff == '0 && pre_cnt != '0) begin
            count_d = cnt_t'(P_REGS);
         end else begin
            count_d = {1'b0, diff};
         end
      end
   end

   always_comb begin
      cid_d = cid_q;
      if (take_checkpoint) begin
         cid_d = cid_q + (dual_branch ? C_W'(2) : C_W'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= ptr_t'(INIT_CNT);
         count_q <= cnt_t'(INIT_CNT);
         cid_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         cid_q   <= cid_d;
      end
   end

   // Initial contents skip the 8 reserved pregs and the L_REGS pregs that
   // hold the architectural mapping out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < P_REGS; i++) begin
            mem_q[i] <= (i < INIT_CNT) ? ptr_t'(8 + L_REGS + i) : '0;
         end
      end else begin
         if (push_en_1) begin
            mem_q[tail_q] <= push_data_1;
         end
         if (push_en_2) begin
            mem_q[tail_q + ptr_t'(push_en_1)] <= push_data_2;
         end
      end
   end

   // Checkpoint slots carry no reset; a slot is only read after being written.
   always_ff @(posedge clk) begin
      if (take_checkpoint) begin
         if (dual_branch) begin
            ckpt_q[cid_q]           <= head_p1;
            ckpt_q[cid_q + C_W'(1)] <= head_p12;
         end else begin
            ckpt_q[cid_q] <= head_g;
         end
      end
   end

`ifdef FREE_LIST_LOW_WATER_EN
   logic low_water_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         low_water_q <= 1'b0;
      end else begin
         low_water_q <= (count_d < cnt_t'(4));
      end
   end

   assign low_water = low_water_q;
`else
   assign low_water = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

   localparam int PW = 7;
   localparam int LW = 5;
   localparam int CN = 2;
   localparam int PR = 128;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pop_1 = 1'b0, pop_2 = 1'b0;
   logic [PW-1:0] alloc_data_1, alloc_data_2;
   logic          alloc_ready;
   logic          push_en_1 = 1'b0, push_en_2 = 1'b0;
   logic [PW-1:0] push_data_1 = '0, push_data_2 = '0;
   logic          take_checkpoint = 1'b0, dual_branch = 1'b0;
   logic [0:0]    current_id;
   logic          restore_flist = 1'b0;
   logic [0:0]    restore_id = '0;
   logic [PW:0]   free_count;
   logic          low_water;

   always #5 clk = ~clk;

   free_list #(.P_ADDR_WIDTH(PW), .L_ADDR_WIDTH(LW), .C_NUM(CN)) dut (
      .clk(clk), .rst_n(rst_n),
      .pop_1(pop_1), .pop_2(pop_2),
      .alloc_data_1(alloc_data_1), .alloc_data_2(alloc_data_2),
      .alloc_ready(alloc_ready),
      .push_en_1(push_en_1), .push_en_2(push_en_2),
      .push_data_1(push_data_1), .push_data_2(push_data_2),
      .take_checkpoint(take_checkpoint), .dual_branch(dual_branch),
      .current_id(current_id),
      .restore_flist(restore_flist), .restore_id(restore_id),
      .free_count(free_count), .low_water(low_water)
   );

   // Pushing more than the list can hold is illegal stimulus.
   always @(posedge clk) begin
      if (rst_n && !restore_flist) begin
         assert (int'(free_count) + int'(push_en_1) + int'(push_en_2)
                 - ((alloc_ready) ? int'(pop_1) + int'(pop_2) : 0) <= PR)
            else $error("overflow: push beyond list capacity");
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: absolute allocation/release sequence numbers; the free
   // list is every preg with sequence number in [pop_t, push_t).
   logic [PW-1:0] store [PR];
   int            pop_t, push_t, cid;
   int            ck [CN];
   bit            ck_v [CN];

   task automatic model_reset();
      for (int i = 0; i < PR; i++) store[i] = (i < 88) ? PW'(40 + i) : '0;
      pop_t  = 0;
      push_t = 88;
      cid    = 0;
      for (int s = 0; s < CN; s++) ck_v[s] = 1'b0;
   endtask

   task automatic model_update();
      int pc, cnt, gr, tgt;
      pc  = int'(pop_1) + int'(pop_2);
      cnt = push_t - pop_t;
      gr  = (cnt >= pc && !restore_flist) ? pc : 0;
      tgt = restore_flist ? ck[restore_id] : 0;
      if (take_checkpoint) begin
         if (dual_branch) begin
            ck[cid] = pop_t + int'(pop_1);
            ck[(cid + 1) % CN] = pop_t + pc;
            ck_v[cid] = 1'b1;
            ck_v[(cid + 1) % CN] = 1'b1;
            cid = (cid + 2) % CN;
         end else begin
            ck[cid] = pop_t + gr;
            ck_v[cid] = 1'b1;
            cid = (cid + 1) % CN;
         end
      end
      if (push_en_1) begin store[push_t % PR] = push_data_1; push_t++; end
      if (push_en_2) begin store[push_t % PR] = push_data_2; push_t++; end
      pop_t = restore_flist ? tgt : pop_t + gr;
      if (restore_flist)
         for (int s = 0; s < CN; s++) if (ck_v[s] && ck[s] > pop_t) ck_v[s] = 1'b0;
   endtask

   task automatic model_check();
      int cnt, exp_lw;
      cnt = push_t - pop_t;
`ifdef FREE_LIST_LOW_WATER_EN
      exp_lw = (cnt < 4) ? 1 : 0;
`else
      exp_lw = 0;
`endif
      chk("rnd_count", int'(free_count), cnt);
      chk("rnd_ready", int'(alloc_ready), (cnt >= int'(pop_1) + int'(pop_2)) ? 1 : 0);
      chk("rnd_cid", int'(current_id), cid);
      chk("rnd_low_water", int'(low_water), exp_lw);
      if (cnt >= 1) chk("rnd_data1", int'(alloc_data_1), int'(store[pop_t % PR]));
      if (cnt >= 1 + int'(pop_1))
         chk("rnd_data2", int'(alloc_data_2), int'(store[(pop_t + int'(pop_1)) % PR]));
   endtask

   task automatic clear_inputs();
      pop_1 = 0; pop_2 = 0; push_en_1 = 0; push_en_2 = 0;
      push_data_1 = '0; push_data_2 = '0;
      take_checkpoint = 0; dual_branch = 0; restore_flist = 0; restore_id = '0;
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic pops(input int n2, input int n1);
      for (int i = 0; i < n2; i++) begin pop_1 = 1; pop_2 = 1; tick(); end
      for (int i = 0; i < n1; i++) begin pop_1 = 1; tick(); end
   endtask

   // Reset asserted mid-cycle with pops, a push and a restore all pending.
   task automatic do_reset();
      pop_1 = 1; pop_2 = 1; push_en_1 = 1; push_data_1 = 7'h55; restore_flist = 1;
      @(negedge clk);
      rst_n = 0;
      #2;
      chk("reset_count_async", int'(free_count), 88);
      @(posedge clk);
      @(negedge clk);
      clear_inputs();
      rst_n = 1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   typedef struct {
      bit            p1, p2, e1, e2;
      logic [PW-1:0] d1, d2;
      int            x_rdy, x_d1, x_d2, x_cnt;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{0, 0, 0, 0, 7'd0, 7'd0, 1, 40, 40, 88};
      tbl[1] = '{1, 1, 0, 0, 7'd0, 7'd0, 1, 40, 41, 88};
      tbl[2] = '{0, 0, 0, 0, 7'd0, 7'd0, 1, 42, 42, 86};
      tbl[3] = '{1, 0, 0, 0, 7'd0, 7'd0, 1, 42, 43, 86};
      tbl[4] = '{0, 1, 1, 1, 7'd5, 7'd6, 1, 43, 43, 85};
      tbl[5] = '{0, 0, 0, 0, 7'd0, 7'd0, 1, 44, 44, 86};

      clear_inputs();
      do_reset();
      chk("reset_cid", int'(current_id), 0);
      chk("reset_low_water", int'(low_water), 0);

      // Table: reset contents, dual pop, single pop, pop with dual push.
      for (int i = 0; i < 6; i++) begin
         pop_1 = tbl[i].p1; pop_2 = tbl[i].p2;
         push_en_1 = tbl[i].e1; push_data_1 = tbl[i].d1;
         push_en_2 = tbl[i].e2; push_data_2 = tbl[i].d2;
         #1;
         chk($sformatf("tbl%0d_ready", i), int'(alloc_ready), tbl[i].x_rdy);
         chk($sformatf("tbl%0d_data1", i), int'(alloc_data_1), tbl[i].x_d1);
         chk($sformatf("tbl%0d_data2", i), int'(alloc_data_2), tbl[i].x_d2);
         chk($sformatf("tbl%0d_count", i), int'(free_count), tbl[i].x_cnt);
         tick();
      end

      // Drain to one entry; a double pop is refused, a single pop granted.
      do_reset();
      pops(43, 1);
      chk("drain_count1", int'(free_count), 1);
      pop_1 = 1; pop_2 = 1; #1;
      chk("drain_refuse_ready", int'(alloc_ready), 0);
      tick();
      chk("drain_refuse_count", int'(free_count), 1);
      chk("drain_refuse_head", int'(alloc_data_1), 127);
      pop_1 = 1; #1;
      chk("drain_single_ready", int'(alloc_ready), 1);
      tick();
      chk("drain_empty_count", int'(free_count), 0);

      // Empty list: a same-cycle push is not visible to the pop.
      pop_1 = 1; push_en_1 = 1; push_data_1 = 7'd9; #1;
      chk("empty_pop_ready", int'(alloc_ready), 0);
      tick();
      chk("empty_push_count", int'(free_count), 1);
      chk("empty_push_data", int'(alloc_data_1), 9);

      // Single checkpoint at head 10 with one pop, then restore.
      do_reset();
      pops(5, 0);
      pop_1 = 1; take_checkpoint = 1; tick();
      chk("ckpt_cid", int'(current_id), 1);
      chk("ckpt_count", int'(free_count), 77);
      pops(0, 5);
      chk("ckpt_pops_count", int'(free_count), 72);
      restore_flist = 1; restore_id = 0; tick();
      chk("restore_count", int'(free_count), 77);
      chk("restore_head", int'(alloc_data_1), 51);

      // Dual-branch checkpoint at head 0 with two pops.
      do_reset();
      pop_1 = 1; pop_2 = 1; take_checkpoint = 1; dual_branch = 1; tick();
      chk("dual_cid", int'(current_id), 0);
      restore_flist = 1; restore_id = 1; tick();
      chk("dual_slot1_count", int'(free_count), 86);
      chk("dual_slot1_head", int'(alloc_data_1), 42);
      restore_flist = 1; restore_id = 0; tick();
      chk("dual_slot0_count", int'(free_count), 87);
      chk("dual_slot0_head", int'(alloc_data_1), 41);

      // Tail wrap with a dual push coinciding with a restore.
      do_reset();
      pops(20, 0);
      take_checkpoint = 1; tick();
      pops(2, 0);
      for (int k = 0; k < 39; k++) begin push_en_1 = 1; push_data_1 = PW'(k); tick(); end
      chk("wrap_pre_count", int'(free_count), 83);
      push_en_1 = 1; push_data_1 = 7'h11; push_en_2 = 1; push_data_2 = 7'h22;
      restore_flist = 1; restore_id = 0; tick();
      chk("wrap_restore_count", int'(free_count), 89);
      chk("wrap_restore_head", int'(alloc_data_1), 80);
      pops(43, 1);
      chk("wrap_walk_count", int'(free_count), 2);
      pop_1 = 1; #1;
      chk("wrap_entry127", int'(alloc_data_1), 8'h11);
      chk("wrap_entry0", int'(alloc_data_2), 8'h22);
      clear_inputs();

      // Randomized traffic against the sequence-number model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int lb, room, np, cnt, pc;
         bit any_v;
         pop_1 = ($urandom_range(0, 1) == 1);
         pop_2 = ($urandom_range(0, 1) == 1);
         any_v = 0;
         for (int s = 0; s < CN; s++) if (ck_v[s]) any_v = 1;
         if (any_v && $urandom_range(0, 15) == 0) begin
            restore_flist = 1;
            restore_id = 1'($urandom_range(0, CN - 1));
            if (!ck_v[restore_id]) restore_id = ~restore_id;
         end
         cnt = push_t - pop_t;
         pc = int'(pop_1) + int'(pop_2);
         if ($urandom_range(0, 7) == 0) begin
            take_checkpoint = 1;
            dual_branch = (!restore_flist && cnt >= pc && $urandom_range(0, 1) == 1);
         end
         lb = pop_t;
         for (int s = 0; s < CN; s++) if (ck_v[s] && ck[s] < lb) lb = ck[s];
         room = PR - (push_t - lb);
         np = $urandom_range(0, 2);
         if (np > room) np = room;
         if (np >= 1) begin push_en_1 = 1; push_data_1 = PW'($urandom_range(0, PR - 1)); end
         if (np == 2) begin push_en_2 = 1; push_data_2 = PW'($urandom_range(0, PR - 1)); end
         #1;
         model_check();
         tick();
      end
      model_check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
